// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake and data bundle for pipelined_barrel_shifter.
// The master side feeds operands and accepts results; the slave side is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [2:0]       SH_MODE;
  logic [AMT_W-1:0] SH_AMT;
  logic [WIDTH-1:0] D_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] D_OUT;
  logic             C_OUT;
  logic             Z_OUT;
  logic             ERR_OUT;

  modport master (
    output IN_VALID, SH_MODE, SH_AMT, D_IN, OUT_READY,
    input  IN_READY, OUT_VALID, D_OUT, C_OUT, Z_OUT, ERR_OUT
  );

  modport slave (
    input  IN_VALID, SH_MODE, SH_AMT, D_IN, OUT_READY,
    output IN_READY, OUT_VALID, D_OUT, C_OUT, Z_OUT, ERR_OUT
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one power-of-two shift per registered stage,
// LSL/LSR/ASR/ROL/ROR with carry-out, zero and illegal-mode flags.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input logic                  CLK,
  input logic                  RST_N,
  pipelined_barrel_shifter_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_LSL = 3'b000,
    MODE_LSR = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } sh_mode_e;

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 8..64");
  end
  if (AMT_W != $clog2(WIDTH)) begin : g_bad_amt_w
    $error("pipelined_barrel_shifter: AMT_W must equal log2(WIDTH)");
  end

  logic [WIDTH-1:0] r_data  [AMT_W];
  logic [2:0]       r_mode  [AMT_W];
  logic [AMT_W-1:0] r_amt   [AMT_W];
  logic             r_carry [AMT_W];
  logic             r_err   [AMT_W];
  logic             r_valid [AMT_W];

  logic [WIDTH-1:0] w_nxt_data  [AMT_W];
  logic [2:0]       w_nxt_mode  [AMT_W];
  logic [AMT_W-1:0] w_nxt_amt   [AMT_W];
  logic             w_nxt_carry [AMT_W];
  logic             w_nxt_err   [AMT_W];
  logic             w_nxt_valid [AMT_W];

  logic w_adv;

  assign w_adv = bus.OUT_READY | ~r_valid[AMT_W-1];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int unsigned SH = 1 << k;

    logic [WIDTH-1:0] w_d;
    logic [2:0]       w_m;
    logic             w_amt_bit;
    logic             w_c;
    logic             w_e;
    logic [WIDTH-1:0] w_nd;
    logic             w_nc;

    if (k == 0) begin : g_src_in
      assign w_d            = bus.D_IN;
      assign w_m            = bus.SH_MODE;
      assign w_amt_bit      = bus.SH_AMT[k];
      assign w_c            = 1'b0;
      assign w_e            = (bus.SH_MODE > MODE_ROR);
      assign w_nxt_amt[k]   = bus.SH_AMT;
      assign w_nxt_valid[k] = bus.IN_VALID;
    end else begin : g_src_reg
      assign w_d            = r_data[k-1];
      assign w_m            = r_mode[k-1];
      assign w_amt_bit      = r_amt[k-1][k];
      assign w_c            = r_carry[k-1];
      assign w_e            = r_err[k-1];
      assign w_nxt_amt[k]   = r_amt[k-1];
      assign w_nxt_valid[k] = r_valid[k-1];
    end

    // ASR fills from the current MSB; earlier ASR stages already replicated the
    // original sign there, so this equals filling with the original sign bit.
    always_comb begin
      w_nd = w_d;
      w_nc = w_c;
      if (w_amt_bit && !w_e) begin
        case (w_m)
          MODE_LSL: begin
            w_nd = {w_d[WIDTH-SH-1:0], {SH{1'b0}}};
            w_nc = w_d[WIDTH-SH];
          end
          MODE_LSR: begin
            w_nd = {{SH{1'b0}}, w_d[WIDTH-1:SH]};
            w_nc = w_d[SH-1];
          end
          MODE_ASR: begin
            w_nd = {{SH{w_d[WIDTH-1]}}, w_d[WIDTH-1:SH]};
            w_nc = w_d[SH-1];
          end
          MODE_ROL: begin
            w_nd = {w_d[WIDTH-SH-1:0], w_d[WIDTH-1:WIDTH-SH]};
            w_nc = w_d[WIDTH-SH];
          end
          MODE_ROR: begin
            w_nd = {w_d[SH-1:0], w_d[WIDTH-1:SH]};
            w_nc = w_d[SH-1];
          end
          default: begin
            w_nd = w_d;
            w_nc = w_c;
          end
        endcase
      end
    end

    assign w_nxt_data[k]  = w_nd;
    assign w_nxt_carry[k] = w_nc;
    assign w_nxt_mode[k]  = w_m;
    assign w_nxt_err[k]   = w_e;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < AMT_W; k++) begin
        r_data[k]  <= '0;
        r_mode[k]  <= '0;
        r_amt[k]   <= '0;
        r_carry[k] <= 1'b0;
        r_err[k]   <= 1'b0;
        r_valid[k] <= 1'b0;
      end
    end else if (w_adv) begin
      for (int unsigned k = 0; k < AMT_W; k++) begin
        r_data[k]  <= w_nxt_data[k];
        r_mode[k]  <= w_nxt_mode[k];
        r_amt[k]   <= w_nxt_amt[k];
        r_carry[k] <= w_nxt_carry[k];
        r_err[k]   <= w_nxt_err[k];
        r_valid[k] <= w_nxt_valid[k];
      end
    end
  end

  assign bus.IN_READY  = w_adv;
  assign bus.OUT_VALID = r_valid[AMT_W-1];
  assign bus.D_OUT     = r_data[AMT_W-1];
  assign bus.C_OUT     = r_carry[AMT_W-1];
  assign bus.ERR_OUT   = r_err[AMT_W-1];
  assign bus.Z_OUT     = (r_data[AMT_W-1] == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH=32: single beats with
// latency checks, backpressure, mid-flight reset and illegal modes.
module tb_pipelined_barrel_shifter;

  localparam logic [2:0] LSL = 3'b000;
  localparam logic [2:0] LSR = 3'b001;
  localparam logic [2:0] ASR = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pipelined_barrel_shifter_if #(.WIDTH(32), .AMT_W(5)) bus ();

  pipelined_barrel_shifter #(.WIDTH(32), .AMT_W(5)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input string tag, input logic [2:0] m, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] ed,
                          input logic ec, input logic ee);
    int lat;
    bus.OUT_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.SH_MODE   = m;
    bus.SH_AMT    = a;
    bus.D_IN      = d;
    #1;
    check({tag, "_in_ready"}, bus.IN_READY, 1);
    tick();
    bus.IN_VALID = 1'b0;
    lat = 1;
    while (!bus.OUT_VALID && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_d"}, bus.D_OUT, ed);
    check({tag, "_c"}, bus.C_OUT, ec);
    check({tag, "_z"}, bus.Z_OUT, (ed == 32'h0));
    check({tag, "_err"}, bus.ERR_OUT, ee);
    tick();
  endtask

  initial begin : main
    logic [31:0] exp_q [8];
    logic [31:0] held;
    int sent, got, stall, extra;
    bit acc, take;

    n_tests = 0;
    n_fail  = 0;
    held    = '0;
    exp_q   = '{32'd0, 32'd2, 32'd8, 32'd24, 32'd64, 32'd160, 32'd384, 32'd896};

    rst_n         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.SH_MODE   = LSL;
    bus.SH_AMT    = '0;
    bus.D_IN      = '0;
    bus.OUT_READY = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_d_out", bus.D_OUT, 0);
    check("rst_c_out", bus.C_OUT, 0);
    check("rst_z_out", bus.Z_OUT, 1);
    check("rst_err_out", bus.ERR_OUT, 0);
    check("rst_in_ready", bus.IN_READY, 1);
    tick();

    run_beat("lsl1",    LSL, 5'd1,  32'h8000_0001, 32'h0000_0002, 1'b1, 1'b0);
    run_beat("asr31",   ASR, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_beat("lsr31",   LSR, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_beat("lsl31",   LSL, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
    run_beat("ror1",    ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0);
    run_beat("rol4",    ROL, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0, 1'b0);
    run_beat("lsr1_z",  LSR, 5'd1,  32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    run_beat("ror0",    ROR, 5'd0,  32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 1'b0);
    run_beat("asr4",    ASR, 5'd4,  32'h8000_00F0, 32'hF800_000F, 1'b0, 1'b0);
    run_beat("illegal", 3'b110, 5'd7, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    run_beat("post_ill", ROL, 5'd4, 32'hF000_0000, 32'h0000_000F, 1'b1, 1'b0);

    // Backpressure: 8 back-to-back beats, 3-cycle stall on first result
    sent  = 0;
    got   = 0;
    stall = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (bus.OUT_VALID && stall < 3) begin
        bus.OUT_READY = 1'b0;
        stall++;
      end else begin
        bus.OUT_READY = 1'b1;
      end
      if (sent < 8) begin
        bus.IN_VALID = 1'b1;
        bus.SH_MODE  = LSL;
        bus.SH_AMT   = 5'(sent);
        bus.D_IN     = 32'(sent);
      end else begin
        bus.IN_VALID = 1'b0;
      end
      #1;
      if (!bus.OUT_READY) begin
        check("bp_in_ready", bus.IN_READY, 0);
        check("bp_out_valid", bus.OUT_VALID, 1);
        if (stall == 1) held = bus.D_OUT;
        else check("bp_hold", bus.D_OUT, held);
      end
      acc  = bus.IN_VALID && bus.IN_READY;
      take = bus.OUT_VALID && bus.OUT_READY;
      if (take) begin
        check("bp_data", bus.D_OUT, exp_q[got]);
        check("bp_carry", bus.C_OUT, 0);
        got++;
      end
      tick();
      if (acc) sent++;
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    check("bp_stall_cycles", stall, 3);
    check("bp_sent", sent, 8);
    check("bp_got", got, 8);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.OUT_VALID) extra++;
      tick();
    end
    check("bp_no_dup", extra, 0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      bus.IN_VALID = 1'b1;
      bus.SH_MODE  = ROL;
      bus.SH_AMT   = 5'(i + 1);
      bus.D_IN     = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    bus.IN_VALID = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out_valid", bus.OUT_VALID, 0);
    check("mid_rst_in_ready", bus.IN_READY, 1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.OUT_VALID) extra++;
      tick();
    end
    check("mid_rst_no_stale", extra, 0);
    run_beat("post_rst", LSL, 5'd8, 32'h00AB_CDEF, 32'hABCD_EF00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the team's 32-bit combinational barrel shifter. It supports five shift/rotate modes and WIDTH-bit data, and reports carry-out, zero and illegal-mode flags. The datapath is split into AMT_W registered stages, one power-of-two shift per stage, with valid/ready handshakes on both sides. It sits between the register-read stage and the ALU result mux of the datapath.

Parameters:
WIDTH, 32, data width; must be a power of two, 8..64.
AMT_W, 5, shift-amount width and pipeline depth; must equal log2(WIDTH). Elaboration error otherwise.

Ports:
CLK  in  1  clock; all state updates on its rising edge.
RST_N  in  1  synchronous, active-low reset.
IN_VALID  in  1  input beat valid.
IN_READY  out  1  block can accept a beat this cycle.
SH_MODE  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101-111 illegal.
SH_AMT  in  AMT_W  shift amount, 0..WIDTH-1.
D_IN  in  WIDTH  operand.
OUT_VALID  out  1  result beat valid.
OUT_READY  in  1  downstream accepts the result.
D_OUT  out  WIDTH  result.
C_OUT  out  1  last bit shifted or rotated out.
Z_OUT  out  1  1 when D_OUT equals 0.
ERR_OUT  out  1  illegal SH_MODE on this beat.

Behaviour:
- Reset: when RST_N=0 at a rising edge, all stage valid bits, D_OUT, C_OUT, ERR_OUT and OUT_VALID clear to 0. Z_OUT reads 1 (D_OUT=0). In-flight beats are discarded. IN_READY=1 in the first cycle after release.
- Handshake: a beat transfers on input when IN_VALID & IN_READY, and on output when OUT_VALID & OUT_READY.
- Global advance: adv = OUT_READY | ~OUT_VALID. IN_READY = adv (combinational).
  - adv=1: every stage loads from the stage before it; a bubble propagates as valid=0.
  - adv=0: all stage registers hold.
- Latency: exactly AMT_W cycles from input acceptance to OUT_VALID when there is no stall. Throughput is 1 beat per cycle. Beats leave in acceptance order, with no loss or duplication.
- Stage k (k=0..AMT_W-1) carries data, mode, amt, carry and valid.
  - If amt[k]=1, stage k applies a shift of 2^k in the beat's mode; otherwise it passes data and carry unchanged.
- Stage-0 carry input is 0.
- Carry update when stage k shifts:
  - LSL: input bit [WIDTH-2^k].
  - LSR/ASR: input bit [2^k-1].
  - ROL: new bit [0].
  - ROR: new bit [WIDTH-1].
- Fill rules: LSL and LSR fill with zeros. ASR fills with input bit [WIDTH-1], which is the original sign bit preserved through all stages.
- SH_AMT=0: D_OUT=D_IN and C_OUT=0 for every legal mode.
- Illegal mode (101-111): D_OUT=D_IN, C_OUT=0 and ERR_OUT=1 for that beat. There is no other side effect and the pipeline does not stall.
- Z_OUT is derived from the final-stage data register, either combinationally or as a registered flag aligned with D_OUT.
- D_OUT, C_OUT, Z_OUT and ERR_OUT are registered and hold stable while OUT_VALID=1 and OUT_READY=0.
- Reset has priority over adv in the same cycle.
- IN_VALID with IN_READY=0: the beat is not taken. The source must hold it.

Test Plan:
1. WIDTH=32, LSL, D_IN=0x8000_0001, amt 1 -> D_OUT=0x0000_0002, C_OUT=1, Z_OUT=0, OUT_VALID exactly 5 cycles after acceptance.
2. D_IN=0x8000_0000, amt 31:
   - ASR -> 0xFFFF_FFFF, C_OUT=0.
   - LSR -> 0x0000_0001, C_OUT=0.
   - LSL of 0x0000_0001, amt 31 -> 0x8000_0000.
3. Rotates:
   - ROR, D_IN=0x0000_0001, amt 1 -> 0x8000_0000, C_OUT=1.
   - ROL, D_IN=0x8000_0001, amt 4 -> 0x0000_0018, C_OUT=0.
   - LSR, D_IN=0x0000_0001, amt 1 -> 0x0000_0000, Z_OUT=1, C_OUT=1.
4. Backpressure: 8 back-to-back beats (LSL by i, D_IN=i), with OUT_READY held low for 3 cycles once the first result appears -> IN_READY=0 during the stall, outputs held stable, all 8 results in order, none lost or duplicated.
5. Reset mid-flight: 3 beats in the pipe, RST_N=0 for 1 cycle -> OUT_VALID=0 the next cycle, no stale beat appears afterwards, and a fresh beat has latency 5.
6. Illegal mode 110, D_IN=0x1234_5678, amt 7 -> D_OUT=0x1234_5678, ERR_OUT=1, C_OUT=0. The next legal beat has ERR_OUT=0.
